vec_length: RTL and testbench

Computes the Euclidean length of a tagged fixed-point direction vector, len = sqrt(x² + y² + z²). It uses a multi-cycle, bit-serial restoring square root. It sits directly upstream of the normalization divider cluster and emits a `TaggedDirection_len` record whose `valid` pulse drives that cluster's `start`. Direction and tag pass through unchanged alongside the computed length.

---
 rtl/vec_length.sv | 178 +++++++++++++++++
 tb/tb_vec_length.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_length.sv
// vec_length: Euclidean length of a tagged Q3.12 direction vector.
// Squares, sums, then a bit-serial restoring square root, one bit per cycle.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 3
`endif

package vec_length_pkg;
    typedef struct packed {
        logic signed [`WIDTH-1:0] x;
        logic signed [`WIDTH-1:0] y;
        logic signed [`WIDTH-1:0] z;
    } Direction;

    typedef struct packed {
        Direction              direction;
        logic [`TAG_SIZE:0]    tag;
    } TaggedDirection;

    typedef struct packed {
        Direction                 direction;
        logic signed [`WIDTH-1:0] len;
        logic [`TAG_SIZE:0]       tag;
    } TaggedDirection_len;
endpackage

module vec_length
    import vec_length_pkg::*;
#(
    parameter int WIDTH  = `WIDTH,
    parameter int Q_BITS = `Q_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  TaggedDirection     TD_in,
    output logic               ready,
    output logic               valid,
    output TaggedDirection_len TDL_out,
    output logic               zero_len
);

    localparam int TAG_SIZE = `TAG_SIZE;
    localparam int W2       = 2 * WIDTH;
    localparam int CW       = $clog2(WIDTH);

    // Struct field widths come from the macros, so the parameters must agree.
    if (WIDTH != `WIDTH || Q_BITS >= WIDTH) begin : g_bad_params
        $error("vec_length: WIDTH must equal `WIDTH and Q_BITS < WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_SUM,
        S_ROOT,
        S_OUT
    } state_t;

    state_t state;
    state_t next;

    Direction          dir;
    logic [TAG_SIZE:0] tag;
    logic [W2-1:0]     sq_x;
    logic [W2-1:0]     sq_y;
    logic [W2-1:0]     sq_z;
    logic [W2-1:0]     rad;
    logic [WIDTH+1:0]  rem;
    logic [WIDTH-1:0]  root;
    logic [CW-1:0]     cnt;

    logic [WIDTH+3:0]  rem_sh;
    logic [WIDTH+3:0]  sub;
    logic [WIDTH+3:0]  rem_next;
    logic              ge;
    logic [WIDTH-1:0]  len_sat;
    logic              unused_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE: if (start) next = S_SQ;
            S_SQ:   next = S_SUM;
            S_SUM:  next = S_ROOT;
            S_ROOT: if (cnt == CW'(WIDTH - 1)) next = S_OUT;
            S_OUT:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
    end

    // One restoring step: bring down the next radicand pair, try subtracting 4*root+1.
    always_comb begin
        rem_sh   = {rem, rad[W2-1 -: 2]};
        sub      = {2'b00, root, 2'b01};
        ge       = (rem_sh >= sub);
        rem_next = ge ? (rem_sh - sub) : rem_sh;
    end

    assign unused_rem = ^rem_next[WIDTH+3:WIDTH+2];

    always_comb begin
        len_sat = root;
        if (root[WIDTH-1]) begin
            len_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir      <= '0;
            tag      <= '0;
            sq_x     <= '0;
            sq_y     <= '0;
            sq_z     <= '0;
            rad      <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            valid    <= 1'b0;
            TDL_out  <= '0;
            zero_len <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        dir <= TD_in.direction;
                        tag <= TD_in.tag;
                    end
                end
                S_SQ: begin
                    sq_x <= W2'(dir.x) * W2'(dir.x);
                    sq_y <= W2'(dir.y) * W2'(dir.y);
                    sq_z <= W2'(dir.z) * W2'(dir.z);
                end
                S_SUM: begin
                    rad  <= sq_x + sq_y + sq_z;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                S_ROOT: begin
                    rad  <= rad << 2;
                    rem  <= rem_next[WIDTH+1:0];
                    root <= {root[WIDTH-2:0], ge};
                    cnt  <= cnt + 1'b1;
                end
                S_OUT: begin
                    TDL_out.direction <= dir;
                    TDL_out.tag       <= tag;
                    TDL_out.len       <= len_sat;
                    zero_len          <= (root == '0);
                    valid             <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_length.sv
// tb_vec_length: directed vectors with hand-computed lengths, latency,
// busy-start, back-to-back and reset-abort checks.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 3
`endif

module tb_vec_length;
    import vec_length_pkg::*;

    localparam int TS = `TAG_SIZE;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    TaggedDirection     TD_in;
    logic               ready;
    logic               valid;
    TaggedDirection_len TDL_out;
    logic               zero_len;

    int checks = 0;
    int errors = 0;

    vec_length dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .TD_in    (TD_in),
        .ready    (ready),
        .valid    (valid),
        .TDL_out  (TDL_out),
        .zero_len (zero_len)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic load(input logic signed [15:0] x, input logic signed [15:0] y,
                        input logic signed [15:0] z, input logic [TS:0] t);
        TD_in.direction.x = x;
        TD_in.direction.y = y;
        TD_in.direction.z = z;
        TD_in.tag         = t;
    endtask

    // Drive start for one edge, then scramble the inputs.
    task automatic issue(input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic signed [15:0] z, input logic [TS:0] t);
        load(x, y, z, t);
        start = 1'b1;
        step();
        start = 1'b0;
        load(16'sh5a5a, -16'sd1234, 16'sh7fff, 4'hf);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string n, input logic signed [15:0] x,
                                input logic signed [15:0] y,
                                input logic signed [15:0] z, input logic [TS:0] t,
                                input logic [15:0] len, input logic zl);
        int lat;
        wait_valid(lat);
        chk({n, " latency"}, lat, 19);
        chk({n, " len"}, TDL_out.len, len);
        chk({n, " tag"}, TDL_out.tag, t);
        chk({n, " dir"}, TDL_out.direction, {x, y, z});
        chk({n, " zero_len"}, zero_len, zl);
        chk({n, " ready"}, ready, 1'b1);
    endtask

    task automatic pulse_end(input string n);
        step();
        chk({n, " pulse_end"}, valid, 1'b0);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (valid === 1'b1) n++;
        end
    endtask

    initial begin
        int lat;
        int nv;

        reset = 1'b1;
        start = 1'b0;
        load(0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        chk("rst ready", ready, 1'b1);
        chk("rst valid", valid, 1'b0);
        chk("rst out", TDL_out, 128'd0);
        chk("rst zero_len", zero_len, 1'b0);

        issue(16'sd12288, 16'sd16384, 16'sd0, 4'd5);
        check_result("v345", 16'sd12288, 16'sd16384, 16'sd0, 4'd5, 16'd20480, 1'b0);
        pulse_end("v345");

        issue(-16'sd4096, -16'sd4096, -16'sd4096, 4'd2);
        check_result("vneg", -16'sd4096, -16'sd4096, -16'sd4096, 4'd2, 16'd7094, 1'b0);
        pulse_end("vneg");

        issue(16'sd4096, 16'sd0, 16'sd0, 4'd1);
        check_result("vunit", 16'sd4096, 16'sd0, 16'sd0, 4'd1, 16'd4096, 1'b0);
        pulse_end("vunit");

        issue(-16'sd32768, -16'sd32768, -16'sd32768, 4'd7);
        check_result("vsat", -16'sd32768, -16'sd32768, -16'sd32768, 4'd7, 16'd32767, 1'b0);
        pulse_end("vsat");

        issue(16'sd0, 16'sd0, 16'sd0, 4'd3);
        check_result("vzero", 16'sd0, 16'sd0, 16'sd0, 4'd3, 16'd0, 1'b1);
        pulse_end("vzero");

        issue(16'sd0, 16'sd0, 16'sd1, 4'd4);
        check_result("vlsb", 16'sd0, 16'sd0, 16'sd1, 4'd4, 16'd1, 1'b0);
        pulse_end("vlsb");

        issue(16'sd3, -16'sd4, 16'sd0, 4'd6);
        check_result("vraw", 16'sd3, -16'sd4, 16'sd0, 4'd6, 16'd5, 1'b0);
        pulse_end("vraw");

        // Starts at cycles 5 and 10 of a busy computation must be ignored.
        issue(16'sd4096, 16'sd0, 16'sd0, 4'd10);
        lat = 0;
        while (valid !== 1'b1 && lat < 40) begin
            start = (lat == 4 || lat == 9);
            if (start) load(16'sd100, 16'sd200, 16'sd300, 4'd9);
            step();
            lat++;
        end
        start = 1'b0;
        chk("busy latency", lat, 19);
        chk("busy tag", TDL_out.tag, 4'd10);
        chk("busy len", TDL_out.len, 16'd4096);
        count_valid(30, nv);
        chk("busy extra valid", nv, 0);

        // Start during the valid cycle is accepted.
        issue(16'sd12288, 16'sd16384, 16'sd0, 4'd11);
        wait_valid(lat);
        chk("b2b first latency", lat, 19);
        chk("b2b first tag", TDL_out.tag, 4'd11);
        load(-16'sd4096, 16'sd0, 16'sd0, 4'd12);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b gap", valid, 1'b0);
        check_result("b2b second", -16'sd4096, 16'sd0, 16'sd0, 4'd12, 16'd4096, 1'b0);
        pulse_end("b2b second");

        // Reset during ROOT iteration 7 aborts with no result.
        issue(16'sd12288, 16'sd16384, 16'sd0, 4'd13);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort ready", ready, 1'b1);
        chk("abort valid", valid, 1'b0);
        chk("abort out", TDL_out, 128'd0);
        chk("abort zero_len", zero_len, 1'b0);
        count_valid(30, nv);
        chk("abort no valid", nv, 0);

        issue(16'sd0, 16'sd16384, 16'sd12288, 4'd14);
        check_result("post abort", 16'sd0, 16'sd16384, 16'sd12288, 4'd14, 16'd20480, 1'b0);
        pulse_end("post abort");

        // Reset wins over a simultaneous start.
        load(16'sd4096, 16'sd0, 16'sd0, 4'd15);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rst+start ready", ready, 1'b1);
        chk("rst+start out", TDL_out, 128'd0);
        count_valid(30, nv);
        chk("rst+start no valid", nv, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
